// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizing and types for the rename register file.
//   REG_NUM         architectural registers (x0..x31)
//   REG_W           data width of one register
//   REG_ID_W        width of an architectural register id
//   RO_BUFFER_SIZE  number of reorder-buffer entries; ids run 1..RO_BUFFER_SIZE
//   RO_BUFFER_ID_W  width of a ROB id; id 0 means "value ready / no producer"
package reg_file_pkg;

  localparam int REG_NUM        = 32;
  localparam int REG_W          = 32;
  localparam int REG_ID_W       = 5;
  localparam int RO_BUFFER_SIZE = 15;
  localparam int RO_BUFFER_ID_W = $clog2(RO_BUFFER_SIZE + 1);

  typedef logic [REG_W-1:0]          reg_t;
  typedef logic [REG_ID_W-1:0]       reg_id_t;
  typedef logic [RO_BUFFER_ID_W-1:0] ro_buffer_id_t;

endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: combinational lookup of one source operand.
//   rs_i            source register id
//   values_i/tags_i current register-file state (all entries, packed)
//   commit_*_i      commit presented this cycle (used only for bypass)
//   value_o/tag_o   committed value and pending ROB id (0 = ready)
// Macro REG_FILE_BYPASS_EN: when defined, a commit landing on rs this cycle
// whose ROB id still owns rs is forwarded (value_from_ro_buffer, tag 0).
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  logic [REG_ID_W-1:0]                   rs_i,
  input  logic [REG_NUM-1:0][REG_W-1:0]         values_i,
  input  logic [REG_NUM-1:0][RO_BUFFER_ID_W-1:0] tags_i,
  input  logic                                  commit_valid_i,
  input  logic [REG_ID_W-1:0]                   commit_rd_i,
  input  logic [RO_BUFFER_ID_W-1:0]             commit_dest_i,
  input  logic [REG_W-1:0]                      commit_value_i,
  output logic [REG_W-1:0]                      value_o,
  output logic [RO_BUFFER_ID_W-1:0]             tag_o
);

  always_comb begin
    value_o = '0;
    tag_o   = '0;
    if (rs_i != '0) begin
      value_o = values_i[rs_i];
      tag_o   = tags_i[rs_i];
`ifdef REG_FILE_BYPASS_EN
      // Only forward when this commit is the latest producer of rs.
      if (commit_valid_i && (commit_rd_i == rs_i) &&
          (tags_i[rs_i] == commit_dest_i)) begin
        value_o = commit_value_i;
        tag_o   = '0;
      end
`endif
    end
  end

`ifndef REG_FILE_BYPASS_EN
  logic unused_commit;
  assign unused_commit = ^{commit_valid_i, commit_rd_i, commit_dest_i, commit_value_i};
`endif

endmodule

// File: rtl/reg_file.sv
// reg_file: architectural register file with rename tags for an OoO core.
//   clk, rst (sync, active-low), rdy (global enable)
//   *_from_issuer           rename request and two source lookups
//   value/tag_of_rs*_to_issuer  operand values and pending ROB ids
//   *_from_ro_buffer        commit (dest 0 = no commit)
//   reset_from_rob_bus      misprediction flush: clears every tag
// Macro REG_FILE_BYPASS_EN: enables commit-to-read forwarding in the read ports.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      valid_from_issuer,
  input  logic [REG_ID_W-1:0]       rd_from_issuer,
  input  logic [RO_BUFFER_ID_W-1:0] dest_from_issuer,
  input  logic [REG_ID_W-1:0]       rs1_from_issuer,
  input  logic [REG_ID_W-1:0]       rs2_from_issuer,
  output logic [REG_W-1:0]          value_of_rs1_to_issuer,
  output logic [REG_W-1:0]          value_of_rs2_to_issuer,
  output logic [RO_BUFFER_ID_W-1:0] tag_of_rs1_to_issuer,
  output logic [RO_BUFFER_ID_W-1:0] tag_of_rs2_to_issuer,
  input  logic [RO_BUFFER_ID_W-1:0] dest_from_ro_buffer,
  input  logic [REG_ID_W-1:0]       rd_from_ro_buffer,
  input  logic [REG_W-1:0]          value_from_ro_buffer,
  input  logic                      reset_from_rob_bus
);

  logic [REG_NUM-1:0][REG_W-1:0]          values_q, values_d;
  logic [REG_NUM-1:0][RO_BUFFER_ID_W-1:0] tags_q,   tags_d;
  logic commit_valid;
  logic rename_valid;

  assign commit_valid = rdy && (dest_from_ro_buffer != '0) && (rd_from_ro_buffer != '0);
  assign rename_valid = rdy && valid_from_issuer && (rd_from_issuer != '0) && !reset_from_rob_bus;

  always_comb begin
    values_d = values_q;
    tags_d   = tags_q;
    if (commit_valid) begin
      values_d[rd_from_ro_buffer] = value_from_ro_buffer;
      // A newer rename may own rd; only the matching producer clears it.
      if (tags_q[rd_from_ro_buffer] == dest_from_ro_buffer)
        tags_d[rd_from_ro_buffer] = '0;
    end
    if (rdy && reset_from_rob_bus)
      tags_d = '0;
    // Applied last so a same-cycle rename overrides the commit's tag clear.
    if (rename_valid)
      tags_d[rd_from_issuer] = dest_from_issuer;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      values_q <= '0;
      tags_q   <= '0;
    end else begin
      values_q <= values_d;
      tags_q   <= tags_d;
    end
  end

  reg_file_read_port u_rs1 (
    .rs_i           (rs1_from_issuer),
    .values_i       (values_q),
    .tags_i         (tags_q),
    .commit_valid_i (commit_valid),
    .commit_rd_i    (rd_from_ro_buffer),
    .commit_dest_i  (dest_from_ro_buffer),
    .commit_value_i (value_from_ro_buffer),
    .value_o        (value_of_rs1_to_issuer),
    .tag_o          (tag_of_rs1_to_issuer)
  );

  reg_file_read_port u_rs2 (
    .rs_i           (rs2_from_issuer),
    .values_i       (values_q),
    .tags_i         (tags_q),
    .commit_valid_i (commit_valid),
    .commit_rd_i    (rd_from_ro_buffer),
    .commit_dest_i  (dest_from_ro_buffer),
    .commit_value_i (value_from_ro_buffer),
    .value_o        (value_of_rs2_to_issuer),
    .tag_o          (tag_of_rs2_to_issuer)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
module tb_reg_file;
  import reg_file_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      rdy;
  logic                      valid_from_issuer;
  logic [REG_ID_W-1:0]       rd_from_issuer;
  logic [RO_BUFFER_ID_W-1:0] dest_from_issuer;
  logic [REG_ID_W-1:0]       rs1_from_issuer;
  logic [REG_ID_W-1:0]       rs2_from_issuer;
  logic [REG_W-1:0]          value_of_rs1_to_issuer;
  logic [REG_W-1:0]          value_of_rs2_to_issuer;
  logic [RO_BUFFER_ID_W-1:0] tag_of_rs1_to_issuer;
  logic [RO_BUFFER_ID_W-1:0] tag_of_rs2_to_issuer;
  logic [RO_BUFFER_ID_W-1:0] dest_from_ro_buffer;
  logic [REG_ID_W-1:0]       rd_from_ro_buffer;
  logic [REG_W-1:0]          value_from_ro_buffer;
  logic                      reset_from_rob_bus;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk                    (clk),
    .rst                    (rst),
    .rdy                    (rdy),
    .valid_from_issuer      (valid_from_issuer),
    .rd_from_issuer         (rd_from_issuer),
    .dest_from_issuer       (dest_from_issuer),
    .rs1_from_issuer        (rs1_from_issuer),
    .rs2_from_issuer        (rs2_from_issuer),
    .value_of_rs1_to_issuer (value_of_rs1_to_issuer),
    .value_of_rs2_to_issuer (value_of_rs2_to_issuer),
    .tag_of_rs1_to_issuer   (tag_of_rs1_to_issuer),
    .tag_of_rs2_to_issuer   (tag_of_rs2_to_issuer),
    .dest_from_ro_buffer    (dest_from_ro_buffer),
    .rd_from_ro_buffer      (rd_from_ro_buffer),
    .value_from_ro_buffer   (value_from_ro_buffer),
    .reset_from_rob_bus     (reset_from_rob_bus)
  );

  task automatic chk_val(input string name, input logic [REG_W-1:0] obs, input logic [REG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk_tag(input string name, input logic [RO_BUFFER_ID_W-1:0] obs,
                         input logic [RO_BUFFER_ID_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_from_issuer    = 1'b0;
    rd_from_issuer       = '0;
    dest_from_issuer     = '0;
    dest_from_ro_buffer  = '0;
    rd_from_ro_buffer    = '0;
    value_from_ro_buffer = '0;
    reset_from_rob_bus   = 1'b0;
  endtask

  task automatic rename(input logic [REG_ID_W-1:0] rd, input logic [RO_BUFFER_ID_W-1:0] id);
    valid_from_issuer = 1'b1;
    rd_from_issuer    = rd;
    dest_from_issuer  = id;
  endtask

  task automatic commit(input logic [RO_BUFFER_ID_W-1:0] id, input logic [REG_ID_W-1:0] rd,
                        input logic [REG_W-1:0] v);
    dest_from_ro_buffer  = id;
    rd_from_ro_buffer    = rd;
    value_from_ro_buffer = v;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    rdy = 1'b1;
    rs1_from_issuer = '0;
    rs2_from_issuer = '0;

    // Reset edge with a rename pending: rename must be discarded.
    #2;
    rename(5'd5, 4'd3);
    tick();
    rst = 1'b1;
    idle();
    rs1_from_issuer = 5'd5;
    #1;
    chk_val("rst_x5_val", value_of_rs1_to_issuer, 32'h0);
    chk_tag("rst_x5_tag", tag_of_rs1_to_issuer, 4'd0);

    // Rename x5->3; same-cycle read still sees the prior mapping.
    rename(5'd5, 4'd3);
    #1;
    chk_tag("rename_same_cycle_tag", tag_of_rs1_to_issuer, 4'd0);
    tick();
    idle();
    #1;
    chk_tag("rename_x5_tag", tag_of_rs1_to_issuer, 4'd3);

    // Commit dest 3 rd 5; same-cycle read depends on bypass build.
    commit(4'd3, 5'd5, 32'hDEADBEEF);
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk_val("commit_same_cycle_val", value_of_rs1_to_issuer, 32'hDEADBEEF);
    chk_tag("commit_same_cycle_tag", tag_of_rs1_to_issuer, 4'd0);
`else
    chk_val("commit_same_cycle_val", value_of_rs1_to_issuer, 32'h0);
    chk_tag("commit_same_cycle_tag", tag_of_rs1_to_issuer, 4'd3);
`endif
    tick();
    idle();
    #1;
    chk_val("commit_x5_val", value_of_rs1_to_issuer, 32'hDEADBEEF);
    chk_tag("commit_x5_tag", tag_of_rs1_to_issuer, 4'd0);

    // Stale commit: x5->3 then x5->7, commit 3 leaves tag 7.
    rename(5'd5, 4'd3);
    tick();
    rename(5'd5, 4'd7);
    tick();
    idle();
    commit(4'd3, 5'd5, 32'h11);
    tick();
    idle();
    rs2_from_issuer = 5'd5;
    #1;
    chk_val("stale_commit_val", value_of_rs2_to_issuer, 32'h11);
    chk_tag("stale_commit_tag", tag_of_rs2_to_issuer, 4'd7);

    // Rename and commit to same rd in one cycle: rename wins the tag.
    commit(4'd7, 5'd5, 32'h22);
    rename(5'd5, 4'd8);
    tick();
    idle();
    #1;
    chk_val("ren_commit_val", value_of_rs2_to_issuer, 32'h22);
    chk_tag("ren_commit_tag", tag_of_rs2_to_issuer, 4'd8);

    // Flush with same-cycle commit and rename.
    rename(5'd1, 4'd2);
    tick();
    rename(5'd2, 4'd4);
    tick();
    idle();
    rs1_from_issuer = 5'd2;
    #1;
    chk_tag("pre_flush_x2_tag", tag_of_rs1_to_issuer, 4'd4);
    reset_from_rob_bus = 1'b1;
    commit(4'd2, 5'd1, 32'h55);
    rename(5'd3, 4'd5);
    tick();
    idle();
    rs1_from_issuer = 5'd1;
    rs2_from_issuer = 5'd2;
    #1;
    chk_val("flush_x1_val", value_of_rs1_to_issuer, 32'h55);
    chk_tag("flush_x1_tag", tag_of_rs1_to_issuer, 4'd0);
    chk_tag("flush_x2_tag", tag_of_rs2_to_issuer, 4'd0);
    rs1_from_issuer = 5'd3;
    rs2_from_issuer = 5'd5;
    #1;
    chk_tag("flush_x3_tag", tag_of_rs1_to_issuer, 4'd0);
    chk_tag("flush_x5_tag", tag_of_rs2_to_issuer, 4'd0);
    chk_val("flush_x5_val_kept", value_of_rs2_to_issuer, 32'h22);

    // x0 is immutable.
    rename(5'd0, 4'd6);
    commit(4'd6, 5'd0, 32'hFF);
    tick();
    idle();
    rs1_from_issuer = 5'd0;
    #1;
    chk_val("x0_val", value_of_rs1_to_issuer, 32'h0);
    chk_tag("x0_tag", tag_of_rs1_to_issuer, 4'd0);

    // rdy low: rename, commit and flush all ignored; reads still valid.
    rename(5'd3, 4'd9);
    tick();
    idle();
    rdy = 1'b0;
    rename(5'd4, 4'd2);
    commit(4'd1, 5'd6, 32'h77);
    reset_from_rob_bus = 1'b1;
    rs1_from_issuer = 5'd1;
    #1;
    chk_val("rdy_low_read_x1", value_of_rs1_to_issuer, 32'h55);
    tick();
    idle();
    rdy = 1'b1;
    rs1_from_issuer = 5'd4;
    rs2_from_issuer = 5'd6;
    #1;
    chk_tag("rdy_low_x4_tag", tag_of_rs1_to_issuer, 4'd0);
    chk_val("rdy_low_x6_val", value_of_rs2_to_issuer, 32'h0);
    rs1_from_issuer = 5'd3;
    #1;
    chk_tag("rdy_low_flush_ignored", tag_of_rs1_to_issuer, 4'd9);

    // Bypass scenario on rs1=6.
    rename(5'd6, 4'd9);
    tick();
    idle();
    rs1_from_issuer = 5'd6;
    commit(4'd9, 5'd6, 32'h1234);
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk_val("bypass_val", value_of_rs1_to_issuer, 32'h1234);
    chk_tag("bypass_tag", tag_of_rs1_to_issuer, 4'd0);
`else
    chk_val("bypass_val", value_of_rs1_to_issuer, 32'h0);
    chk_tag("bypass_tag", tag_of_rs1_to_issuer, 4'd9);
`endif
    tick();
    idle();
    #1;
    chk_val("post_bypass_val", value_of_rs1_to_issuer, 32'h1234);
    chk_tag("post_bypass_tag", tag_of_rs1_to_issuer, 4'd0);

    // Reset wins over rdy low, commit and flush.
    rst = 1'b0;
    rdy = 1'b0;
    commit(4'd2, 5'd1, 32'hABCD);
    reset_from_rob_bus = 1'b1;
    tick();
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    rs1_from_issuer = 5'd1;
    rs2_from_issuer = 5'd3;
    #1;
    chk_val("rst2_x1_val", value_of_rs1_to_issuer, 32'h0);
    chk_tag("rst2_x3_tag", tag_of_rs2_to_issuer, 4'd0);
    rs1_from_issuer = 5'd6;
    #1;
    chk_val("rst2_x6_val", value_of_rs1_to_issuer, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
